// File: rtl/rcc_lse_css.sv
// LSE clock security system: watches the synchronised LSE/8 toggle on lsi_clk and latches a
// sticky fail when it stops. Define RCC_LSECSS_FREQ_HIGH_CHECK_EN to also fail on short periods.
module rcc_lse_css #(
    parameter int unsigned SYNC_STAGE = 2,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned MIN_PERIOD = 2
) (
    input  logic       lsi_clk,
    input  logic       vsw_rst,
    input  logic       lsecsson,
    input  logic       lserdy,
    input  logic       lse_tgl,
    output logic       lsecss_fail,
    output logic       lsecss_irq,
    output logic [1:0] css_state
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StArm  = 2'b01,
        StMon  = 2'b10,
        StFail = 2'b11
    } css_state_e;

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

    if (SYNC_STAGE < 2 || TIMEOUT < 2 || TIMEOUT > (2 ** CNT_W) - 1 || MIN_PERIOD < 1)
    begin : g_param_err
        $error("rcc_lse_css: illegal parameter set");
    end

    logic [SYNC_STAGE-1:0] tgl_sync_q;
    logic [SYNC_STAGE-1:0] rdy_sync_q;
    logic                  tgl_last_q;
    logic                  css_on_q;
    css_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  fail_q, irq_q;
    logic                  fail_d, irq_d;
    logic                  tgl_edge;
    logic                  arm;

    assign tgl_edge = tgl_sync_q[SYNC_STAGE-1] ^ tgl_last_q;
    assign arm      = css_on_q & rdy_sync_q[SYNC_STAGE-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (arm) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                if (!arm) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (tgl_edge) begin
                    state_d = StMon;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StFail;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StMon: begin
                if (!arm) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (tgl_edge) begin
`ifdef RCC_LSECSS_FREQ_HIGH_CHECK_EN
                    // An edge arriving before MIN_PERIOD cycles means a glitching or fast LSE.
                    if (cnt_q < CNT_W'(MIN_PERIOD - 1)) begin
                        state_d = StFail;
                    end else begin
                        cnt_d = '0;
                    end
`else
                    cnt_d = '0;
`endif
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StFail;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        fail_d = (state_d == StFail);
        irq_d  = (state_d == StFail) && (state_q != StFail);
    end

    always_ff @(posedge lsi_clk or posedge vsw_rst) begin
        if (vsw_rst) begin
            tgl_sync_q <= '0;
            rdy_sync_q <= '0;
            tgl_last_q <= 1'b0;
            css_on_q   <= 1'b0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            fail_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            tgl_sync_q <= {tgl_sync_q[SYNC_STAGE-2:0], lse_tgl};
            rdy_sync_q <= {rdy_sync_q[SYNC_STAGE-2:0], lserdy};
            tgl_last_q <= tgl_sync_q[SYNC_STAGE-1];
            // Once enabled, only the domain reset can disable monitoring.
            css_on_q   <= css_on_q | lsecsson;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            irq_q      <= irq_d;
        end
    end

    assign lsecss_fail = fail_q;
    assign lsecss_irq  = irq_q;
    assign css_state   = state_q;

endmodule

// File: tb/tb_rcc_lse_css.sv
// Randomised scoreboard bench for rcc_lse_css; the reference model tracks event timestamps
// (enable, last detected edge, fail) over the recorded input history.
module tb_rcc_lse_css;

    localparam int SYNC_STAGE = 2;
    localparam int CNT_W      = 8;
    localparam int TIMEOUT    = 64;
    localparam int MIN_PERIOD = 2;

    logic       lsi_clk  = 1'b0;
    logic       vsw_rst  = 1'b1;
    logic       lsecsson = 1'b0;
    logic       lserdy   = 1'b0;
    logic       lse_tgl  = 1'b0;
    logic       lsecss_fail;
    logic       lsecss_irq;
    logic [1:0] css_state;

    rcc_lse_css #(
        .SYNC_STAGE(SYNC_STAGE),
        .CNT_W     (CNT_W),
        .TIMEOUT   (TIMEOUT),
        .MIN_PERIOD(MIN_PERIOD)
    ) dut (
        .lsi_clk    (lsi_clk),
        .vsw_rst    (vsw_rst),
        .lsecsson   (lsecsson),
        .lserdy     (lserdy),
        .lse_tgl    (lse_tgl),
        .lsecss_fail(lsecss_fail),
        .lsecss_irq (lsecss_irq),
        .css_state  (css_state)
    );

    always #5 lsi_clk = ~lsi_clk;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       fail;
        logic       irq;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_extra = 0;
    int   n_efail = 0;
    bit   done    = 0;

    // Reference model state: input history per cycle since reset release, plus timestamps.
    bit t_hist[$];
    bit r_hist[$];
    int cyc      = 0;
    bit css_on   = 0;
    bit active   = 0;
    bit seen     = 0;
    bit failed   = 0;
    int ref_cyc  = 0;
    int fail_cyc = -1;

    bit tgl_cur  = 0;
    int gap_left = 0;

    function automatic bit tgl_at(int k);
        return (k < 0) ? 1'b0 : t_hist[k];
    endfunction

    function automatic bit rdy_at(int k);
        return (k < 0) ? 1'b0 : r_hist[k];
    endfunction

    function automatic void model_advance(bit on);
        bit edge_seen;
        bit armed;
        int since;
        edge_seen = tgl_at(cyc - SYNC_STAGE) ^ tgl_at(cyc - SYNC_STAGE - 1);
        armed     = css_on && rdy_at(cyc - SYNC_STAGE);
        since     = cyc - ref_cyc;
        if (!failed) begin
            if (!armed) begin
                active = 0;
            end else if (!active) begin
                active  = 1;
                seen    = 0;
                ref_cyc = cyc + 1;
            end else if (edge_seen) begin
`ifdef RCC_LSECSS_FREQ_HIGH_CHECK_EN
                if (seen && since < MIN_PERIOD - 1) begin
                    failed   = 1;
                    fail_cyc = cyc + 1;
                end else begin
                    seen    = 1;
                    ref_cyc = cyc + 1;
                end
`else
                seen    = 1;
                ref_cyc = cyc + 1;
`endif
            end else if (since >= TIMEOUT - 1) begin
                failed   = 1;
                fail_cyc = cyc + 1;
            end
        end
        css_on = css_on | on;
    endfunction

    // Called at posedge+1; records expectation for this cycle, drives inputs, advances.
    task automatic step(input bit t, input bit r, input bit on);
        exp_t e;
        e.cyc  = cyc;
        e.st   = failed ? 2'b11 : (!active ? 2'b00 : (seen ? 2'b10 : 2'b01));
        e.fail = failed;
        e.irq  = failed && (fail_cyc == cyc);
        exp_q.push_back(e);
        lse_tgl  = t;
        lserdy   = r;
        lsecsson = on;
        t_hist.push_back(t);
        r_hist.push_back(r);
        model_advance(on);
        cyc++;
        @(posedge lsi_clk);
        #1;
    endtask

    // Reset is raised mid-cycle; the monitor later in the same cycle must already see IDLE.
    task automatic do_reset();
        exp_t e;
        #1;
        vsw_rst  = 1'b1;
        lse_tgl  = 1'b0;
        lserdy   = 1'b0;
        lsecsson = 1'b0;
        #1;
        n_extra++;
        if (css_state !== 2'b00 || lsecss_fail !== 1'b0 || lsecss_irq !== 1'b0) begin
            n_efail++;
            $display("FAIL async reset: got state=%0d fail=%b irq=%b, expected state=0 fail=0 irq=0",
                     css_state, lsecss_fail, lsecss_irq);
        end
        e.cyc  = -1;
        e.st   = 2'b00;
        e.fail = 1'b0;
        e.irq  = 1'b0;
        exp_q.push_back(e);
        @(posedge lsi_clk);
        #1;
        vsw_rst = 1'b0;
        t_hist.delete();
        r_hist.delete();
        cyc      = 0;
        css_on   = 0;
        active   = 0;
        seen     = 0;
        failed   = 0;
        ref_cyc  = 0;
        fail_cyc = -1;
        tgl_cur  = 0;
        gap_left = 0;
    endtask

    // hi == 0 freezes the toggle; otherwise it toggles every lo..hi cycles.
    task automatic drive(input int n, input int lo, input int hi, input bit r, input bit on);
        for (int i = 0; i < n; i++) begin
            if (hi != 0) begin
                if (gap_left <= 0) begin
                    tgl_cur  = ~tgl_cur;
                    gap_left = int'($urandom_range(hi, lo));
                end
                gap_left--;
            end
            step(tgl_cur, r, on);
        end
    endtask

    always @(negedge lsi_clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests <= n_tests + 1;
            if (css_state !== e.st || lsecss_fail !== e.fail || lsecss_irq !== e.irq) begin
                n_fail <= n_fail + 1;
                $display("FAIL outputs cycle %0d: got state=%0d fail=%b irq=%b, expected state=%0d fail=%b irq=%b",
                         e.cyc, css_state, lsecss_fail, lsecss_irq, e.st, e.fail, e.irq);
            end
        end
    end

    initial begin
        #5_000_000;
        if (!done) begin
            $display("FAIL watchdog: stimulus did not complete in time");
            $display("[TB] %0d tests run, %0d failed", n_tests + n_extra + 1,
                     n_fail + n_efail + 1);
            $finish;
        end
    end

    initial begin
        @(posedge lsi_clk);
        #1;

        // Enable path, then LSE stop and sticky fail while toggling resumes.
        do_reset();
        drive(1000, 3, 5, 1'b1, 1'b1);
        drive(100, 0, 0, 1'b1, 1'b1);
        drive(500, 3, 5, 1'b1, 1'b0);

        // No first edge ever arrives.
        do_reset();
        drive(90, 0, 0, 1'b1, 1'b1);

        // Ready drop returns to IDLE; css_on stays set with lsecsson low.
        do_reset();
        drive(60, 4, 4, 1'b1, 1'b1);
        drive(30, 4, 4, 1'b0, 1'b1);
        drive(80, 4, 4, 1'b1, 1'b0);

        // Enable was cleared by reset: ready alone must not arm.
        do_reset();
        drive(40, 4, 4, 1'b1, 1'b0);

        // Edge exactly on the last allowed cycle, then one cycle too late.
        drive(40, 3, 5, 1'b1, 1'b1);
        drive(400, 64, 64, 1'b1, 1'b1);
        drive(200, 65, 65, 1'b1, 1'b1);
        do_reset();

        // Two edges on consecutive cycles in MON.
        drive(40, 4, 4, 1'b1, 1'b1);
        tgl_cur = ~tgl_cur;
        step(tgl_cur, 1'b1, 1'b1);
        tgl_cur = ~tgl_cur;
        step(tgl_cur, 1'b1, 1'b1);
        gap_left = 4;
        drive(40, 4, 4, 1'b1, 1'b1);

        // Randomised segments.
        for (int s = 0; s < 60; s++) begin
            int k;
            int lo;
            k  = int'($urandom_range(7, 0));
            lo = int'($urandom_range(70, 1));
            if (k == 0) begin
                do_reset();
            end else if (k == 1) begin
                drive(int'($urandom_range(120, 10)), 0, 0, 1'b1, 1'b1);
            end else begin
                drive(int'($urandom_range(150, 20)), lo, lo + int'($urandom_range(8, 0)),
                      ($urandom_range(9, 0) != 0), ($urandom_range(1, 0) != 0));
            end
        end

        @(negedge lsi_clk);
        #1;
        done = 1;
        n_extra++;
        if (exp_q.size() != 0) begin
            n_efail++;
            $display("FAIL scoreboard: %0d expectations never checked", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests + n_extra, n_fail + n_efail);
        $finish;
    end

endmodule
